ref_shallow_fifo_ctl: RTL and testbench
=======================================

Name: ref_shallow_fifo_ctl

Overview:
- Single-clock FIFO controller that owns the write and read ports of the team's inferred shallow (distributed) RAM.
- Converts an upstream valid/ready push stream into RAM writes.
- Presents a first-word-fall-through valid/ready pop stream built from the RAM's registered-address read port.
- Guarantees the RAM never reads an entry in the same cycle it is written, so the RAM can be used with FAST_READ=0 and never produces collision data on a valid output.

Parameters:
- ADDR_WIDTH, 5: RAM address bits; depth DEPTH = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 64: payload width.
- AF_THRESH, DEPTH-2: almost_full asserts when occupancy >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk, in, 1: single clock for all logic and both RAM ports.
- rst_n, in, 1: synchronous reset, active low.
- flush, in, 1: synchronous clear of FIFO contents.
- din_valid, in, 1: upstream word valid.
- din_ready, out, 1: FIFO can accept a word.
- din_data, in, DATA_WIDTH: upstream payload.
- dout_valid, out, 1: head word valid.
- dout_ready, in, 1: downstream accepts head word.
- dout_data, out, DATA_WIDTH: head payload; pass-through of ram_rd_data.
- ram_wr_en, out, 1: RAM write enable.
- ram_wr_addr, out, ADDR_WIDTH: RAM write address.
- ram_wr_data, out, DATA_WIDTH: RAM write data.
- ram_rd_addr, out, ADDR_WIDTH: RAM read address; the RAM registers it internally.
- ram_rd_data, in, DATA_WIDTH: RAM read data, equal to mem at the registered address.
- count, out, ADDR_WIDTH+1: occupancy, 0..DEPTH.
- almost_full, out, 1: count >= AF_THRESH.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - RAM addresses use the low ADDR_WIDTH bits.
  - wr_ptr_c is a registered copy of wr_ptr from the previous cycle (the committed write pointer).
- Push:
  - Push = din_valid & din_ready.
  - On push: ram_wr_en=1, ram_wr_addr=wr_ptr[ADDR_WIDTH-1:0], ram_wr_data=din_data (all combinational); wr_ptr increments at the edge.
- Pop:
  - Pop = dout_valid & dout_ready.
  - rd_ptr_nxt = rd_ptr + pop.
  - ram_rd_addr = rd_ptr_nxt[ADDR_WIDTH-1:0], combinational, so the RAM's registered address always equals rd_ptr.
- dout_valid:
  - Registered; next value = (wr_ptr != rd_ptr_nxt). This uses the pre-edge wr_ptr, so a word written at edge N cannot be reported valid before edge N+1.
  - Latency into an empty FIFO: push at edge N gives dout_valid=1 after edge N+1 (two cycles).
  - While dout_valid=1, the registered read address never equals a just-written address; RAM collision X may appear only while dout_valid=0.
- din_ready:
  - Registered; next value = (wr_ptr_nxt - rd_ptr_nxt) < DEPTH.
  - Push and pop in the same cycle at full: the push is refused (din_ready was 0); din_ready returns to 1 the next cycle.
- count and almost_full:
  - count = wr_ptr - rd_ptr (mod 2^(ADDR_WIDTH+1)), combinational from registered pointers.
  - almost_full is registered from the next-state count.
- Wrap-around: pointers wrap naturally; full is defined as (wr_ptr ^ rd_ptr) == {1, 0...0}.
- Pop when dout_valid=0: ignored. Push when din_ready=0: ignored and data dropped; upstream must hold.
- Reset (rst_n=0 at edge):
  - wr_ptr=rd_ptr=wr_ptr_c=0; dout_valid=0; din_ready=0; almost_full=0; count=0.
  - din_ready becomes 1 at the first edge with rst_n=1.
  - Reset mid-stream discards all contents; RAM contents are not cleared.
- Flush (flush=1 at edge, rst_n=1):
  - Pointers cleared as in reset; dout_valid=0; din_ready=1.
  - Push and pop in the flush cycle are discarded, with ram_wr_en forced to 0.
  - rst_n has priority over flush.

Optional Feature:
- Macro REF_SHALLOW_FIFO_STATS_EN.
- Defined:
  - Adds output hwm [ADDR_WIDTH:0]: a registered high-water mark equal to the maximum of next-state count.
  - Cleared by rst_n and by flush.
  - Adds output ovf_sticky [1]: set when din_valid=1 & din_ready=0; cleared only by rst_n.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan (ADDR_WIDTH=2, DEPTH=4, AF_THRESH=3):
- Reset release, then one push of 0xA1 at edge 1 -> dout_valid=0 after edge 1; dout_valid=1 with dout_data=0xA1 after edge 2; count=1 after edge 1.
- Push 4 words with dout_ready=0 -> din_ready=0 and count=4 after the 4th push; almost_full=1 from count=3; a 5th din_valid is not accepted.
- At full, assert din_valid and dout_ready together -> the pop occurs and the push is refused; din_ready=1 next cycle; count=3.
- Stream 10 words 0..9 with both sides always ready -> output order 0..9 exactly across two pointer wraps; no X on dout_data while dout_valid=1; RAM instance run with FAST_READ=0.
- flush asserted with count=2 alongside a push -> count=0, dout_valid=0, ram_wr_en=0 in the flush cycle; the next push shows dout_valid=1 two edges later.
- rst_n low for one edge mid-stream with count=3 -> all outputs return to reset values; din_ready=1 after the next edge; with REF_SHALLOW_FIFO_STATS_EN defined, hwm=0 and ovf_sticky=0.

Source files
------------

// File: rtl/ref_shallow_fifo_ctl.sv
// Single-clock FIFO controller for an inferred shallow RAM with a registered read address.
// Optional occupancy statistics (hwm, ovf_sticky) are enabled by REF_SHALLOW_FIFO_STATS_EN.
module ref_shallow_fifo_ctl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   count,
`ifdef REF_SHALLOW_FIFO_STATS_EN
  output logic [ADDR_WIDTH:0]   hwm,
  output logic                  ovf_sticky,
`endif
  output logic                  almost_full
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AF_CNT   = PW'(AF_THRESH);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_c;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, wr_ptr_c_nxt, count_nxt;
  logic          clear, push, pop;

  always_comb begin
    clear        = ~rst_n | flush;
    push         = din_valid & din_ready & ~clear;
    pop          = dout_valid & dout_ready;
    wr_ptr_nxt   = clear ? '0 : wr_ptr + PW'(push);
    rd_ptr_nxt   = clear ? '0 : rd_ptr + PW'(pop);
    // Only words committed before this edge may become visible at the head.
    wr_ptr_c_nxt = clear ? '0 : wr_ptr;
    count_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  end

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = din_data;
  // The RAM registers this, so its internal address always tracks rd_ptr.
  assign ram_rd_addr = rd_ptr_nxt[ADDR_WIDTH-1:0];
  assign dout_data   = ram_rd_data;
  assign count       = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_ptr_c    <= '0;
      dout_valid  <= 1'b0;
      din_ready   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr_c    <= wr_ptr_c_nxt;
      dout_valid  <= (wr_ptr_c_nxt != rd_ptr_nxt);
      din_ready   <= (count_nxt != FULL_CNT);
      almost_full <= (count_nxt >= AF_CNT);
    end
  end

  // The head is valid exactly when committed words remain unread.
  a_valid_tracks_commit: assert property (@(posedge clk) disable iff (!rst_n)
    dout_valid == (wr_ptr_c != rd_ptr));

`ifdef REF_SHALLOW_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hwm        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (flush)
        hwm <= '0;
      else if (count_nxt > hwm)
        hwm <= count_nxt;
      if (din_valid & ~din_ready)
        ovf_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ref_shallow_fifo_ctl.sv
// Randomized and directed bench for ref_shallow_fifo_ctl with a queue-based reference model
// and a registered-address RAM model that poisons collision reads.
module tb_ref_shallow_fifo_ctl;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int AF = 3;

  logic          clk = 1'b0;
  logic          rst_n, flush, din_valid, din_ready, dout_valid, dout_ready;
  logic [DW-1:0] din_data, dout_data, ram_wr_data, ram_rd_data;
  logic          ram_wr_en, almost_full;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [AW:0]   count;
`ifdef REF_SHALLOW_FIFO_STATS_EN
  logic [AW:0]   hwm;
  logic          ovf_sticky;
`endif

  always #5 clk = ~clk;

  ref_shallow_fifo_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .count(count),
`ifdef REF_SHALLOW_FIFO_STATS_EN
    .hwm(hwm), .ovf_sticky(ovf_sticky),
`endif
    .almost_full(almost_full));

  // RAM with registered read address; a same-cycle read/write collision yields poison.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_q = '0;
  logic          ram_coll = 1'b0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_q     <= ram_rd_addr;
    ram_coll <= ram_wr_en && (ram_wr_addr == ram_rd_addr);
  end
  assign ram_rd_data = ram_coll ? 16'hDEAD : mem[rd_q];

  typedef struct {
    int          stamp;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] popped[$];
  int            e = 0;
  int            wr_idx = 0;
  bit            m_ready = 0, m_af = 0, m_ovf = 0;
  int            m_hwm = 0;
  int            checks = 0, errors = 0;

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].stamp < e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic compare();
    chk("count", 32'(count), q.size());
    chk("din_ready", 32'(din_ready), 32'(m_ready));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid()));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    if (m_valid()) begin
      chk("dout_data", 32'(dout_data), 32'(q[0].data));
      chk("no_collision", 32'(ram_coll), 0);
    end
`ifdef REF_SHALLOW_FIFO_STATS_EN
    chk("hwm", 32'(hwm), m_hwm);
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
`endif
  endtask

  task automatic cycle(bit r, bit f, bit dv, logic [DW-1:0] dd, bit dr);
    bit pu, po;
    rst_n = r; flush = f; din_valid = dv; din_data = dd; dout_ready = dr;
    #1;
    pu = dv && m_ready && r && !f;
    po = m_valid() && dr && r && !f;
    chk("ram_wr_en", 32'(ram_wr_en), 32'(pu));
    if (pu) begin
      chk("ram_wr_addr", 32'(ram_wr_addr), wr_idx % DEPTH);
      chk("ram_wr_data", 32'(ram_wr_data), 32'(dd));
    end
    @(posedge clk);
    e++;
    if (r && dv && !m_ready) m_ovf = 1;
    if (!r || f) begin
      q.delete();
      wr_idx = 0;
    end else begin
      if (po) begin
        popped.push_back(q[0].data);
        void'(q.pop_front());
      end
      if (pu) begin
        q.push_back('{e, dd});
        wr_idx++;
      end
    end
    if (!r) m_ovf = 0;
    m_ready = r && (q.size() < DEPTH);
    m_af    = r && (q.size() >= AF);
    if (!r || f) m_hwm = 0;
    else if (q.size() > m_hwm) m_hwm = q.size();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int sent;
    rst_n = 0; flush = 0; din_valid = 0; din_data = '0; dout_ready = 0;
    @(negedge clk);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_din_ready", 32'(din_ready), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_almost_full", 32'(almost_full), 0);

    cycle(1, 0, 0, 0, 0);
    chk("release_din_ready", 32'(din_ready), 1);
    cycle(1, 0, 1, 16'h00A1, 0);
    chk("first_push_valid", 32'(dout_valid), 0);
    chk("first_push_count", 32'(count), 1);
    cycle(1, 0, 0, 0, 0);
    chk("first_valid", 32'(dout_valid), 1);
    chk("first_data", 32'(dout_data), 32'h00A1);
    cycle(1, 0, 0, 0, 1);
    chk("first_pop_count", 32'(count), 0);

    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, 16'(16'h10 + i), 0);
      if (i == 2) chk("af_at_3", 32'(almost_full), 1);
    end
    chk("full_din_ready", 32'(din_ready), 0);
    chk("full_count", 32'(count), 4);
    cycle(1, 0, 1, 16'h0055, 0);
    chk("fifth_refused", 32'(count), 4);
    cycle(1, 0, 1, 16'h0066, 1);
    chk("full_pushpop_count", 32'(count), 3);
    chk("full_pushpop_ready", 32'(din_ready), 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 1);
    chk("drained", 32'(count), 0);

    popped.delete();
    sent = 0;
    for (int k = 0; k < 60 && popped.size() < 10; k++) begin
      bit v, acc;
      v = sent < 10;
      acc = v && m_ready;
      cycle(1, 0, v, 16'(sent), 1);
      if (acc) sent++;
    end
    chk("stream_len", popped.size(), 10);
    for (int j = 0; j < popped.size(); j++) chk("stream_order", 32'(popped[j]), j);

    cycle(1, 0, 1, 16'h0031, 0);
    cycle(1, 0, 1, 16'h0032, 0);
    chk("preflush_count", 32'(count), 2);
    cycle(1, 1, 1, 16'h0077, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(dout_valid), 0);
    chk("flush_ready", 32'(din_ready), 1);
    cycle(1, 0, 1, 16'h0088, 0);
    chk("postflush_valid_1", 32'(dout_valid), 0);
    cycle(1, 0, 0, 0, 0);
    chk("postflush_valid_2", 32'(dout_valid), 1);
    chk("postflush_data", 32'(dout_data), 32'h0088);

    cycle(1, 0, 1, 16'h0089, 0);
    cycle(1, 0, 1, 16'h008A, 0);
    chk("prereset_count", 32'(count), 3);
    cycle(0, 0, 1, 16'h0099, 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ready", 32'(din_ready), 0);
    chk("midrst_valid", 32'(dout_valid), 0);
    chk("midrst_af", 32'(almost_full), 0);
`ifdef REF_SHALLOW_FIFO_STATS_EN
    chk("midrst_hwm", 32'(hwm), 0);
    chk("midrst_ovf", 32'(ovf_sticky), 0);
`endif
    cycle(1, 0, 0, 0, 0);
    chk("midrst_release_ready", 32'(din_ready), 1);

    for (int k = 0; k < 500; k++) begin
      cycle($urandom_range(0, 63) != 0, $urandom_range(0, 31) == 0,
            1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
